intersection_phase_scheduler: RTL and testbench

- Demand-driven phase scheduler for a two-road intersection. Drives the two red/yellow/green lamp sets and pedestrian WALK lamps.
- Arbitrates three request classes: vehicle presence, latched pedestrian push-buttons and emergency preemption. It replaces fixed-period sequencing with minimum/maximum green timing.
- Sits between the roadside sensor/button synchronisers and the lamp drivers.

---
 rtl/intersection_phase_scheduler.sv | 168 ++++++++++++++++
 tb/tb_intersection_phase_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/intersection_phase_scheduler.sv
// rtl/intersection_phase_scheduler.sv - demand-driven two-road phase scheduler with pedestrian and emergency handling
module intersection_phase_scheduler #(
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 5,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car1,
    input  logic       car2,
    input  logic       ped_req1,
    input  logic       ped_req2,
    input  logic [1:0] emerg_req,
    output logic       red1,
    output logic       yellow1,
    output logic       green1,
    output logic       red2,
    output logic       yellow2,
    output logic       green2,
    output logic       walk1,
    output logic       walk2,
    output logic       preempt_active,
    output logic [2:0] phase
);

    localparam logic [2:0] S_AR_INIT = 3'd0;
    localparam logic [2:0] S_G1      = 3'd1;
    localparam logic [2:0] S_Y1      = 3'd2;
    localparam logic [2:0] S_AR1     = 3'd3;
    localparam logic [2:0] S_G2      = 3'd4;
    localparam logic [2:0] S_Y2      = 3'd5;
    localparam logic [2:0] S_AR2     = 3'd6;

    localparam logic [CNT_W-1:0] L_GMIN_END  = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] L_GMAX_END  = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] L_YEL_END   = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] L_AR_END    = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] L_WALK_END  = CNT_W'(WALK_T - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_wcnt;
    logic             r_pend1;
    logic             r_pend2;
    logic             r_walk1;
    logic             r_walk2;
    logic             r_preempt;

    logic w_em1;
    logic w_em2;
    logic w_em_any;
    logic w_demand1;
    logic w_demand2;
    logic w_min_ok;
    logic w_max_hit;
    logic w_in_green;
    logic w_hold;
    logic w_start1;
    logic w_start2;

    // Road 1 wins when both emergency bits are set.
    assign w_em1     = emerg_req[0];
    assign w_em2     = emerg_req[1] & ~emerg_req[0];
    assign w_em_any  = |emerg_req;
    assign w_demand1 = car1 | r_pend1;
    assign w_demand2 = car2 | r_pend2;

    // A preempted green behaves as if its counter had already saturated.
    assign w_min_ok   = (r_cnt >= L_GMIN_END) | r_preempt;
    assign w_max_hit  = (r_cnt == L_GMAX_END) | r_preempt;
    assign w_in_green = (r_state == S_G1) | (r_state == S_G2);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_AR_INIT: if (r_cnt == L_AR_END) w_next = S_G1;
            S_G1: begin
                if (w_em2)
                    w_next = S_Y1;
                else if (!w_em1 && w_demand2 && w_min_ok && (!car1 || w_max_hit))
                    w_next = S_Y1;
            end
            S_Y1:  if (r_cnt == L_YEL_END) w_next = S_AR1;
            S_AR1: if (r_cnt == L_AR_END) w_next = w_em1 ? S_G1 : S_G2;
            S_G2: begin
                if (w_em1)
                    w_next = S_Y2;
                else if (!w_em2 && w_demand1 && w_min_ok && (!car2 || w_max_hit))
                    w_next = S_Y2;
            end
            S_Y2:  if (r_cnt == L_YEL_END) w_next = S_AR2;
            S_AR2: if (r_cnt == L_AR_END) w_next = w_em2 ? S_G2 : S_G1;
            default: w_next = S_AR_INIT;
        endcase
    end

    assign w_hold   = ((w_next == S_G1) && w_em1) || ((w_next == S_G2) && w_em2);
    assign w_start1 = (w_next == S_G1) && (r_state != S_G1) && (r_pend1 || ped_req1) && !w_em_any;
    assign w_start2 = (w_next == S_G2) && (r_state != S_G2) && (r_pend2 || ped_req2) && !w_em_any;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_AR_INIT;
            r_cnt     <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_preempt <= w_hold;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (w_hold)
                r_cnt <= L_GMAX_END;
            else if (!(w_in_green && r_cnt == L_GMAX_END))
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // A button press during an active WALK is absorbed rather than queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend1 <= 1'b0;
            r_pend2 <= 1'b0;
            r_walk1 <= 1'b0;
            r_walk2 <= 1'b0;
            r_wcnt  <= '0;
        end else begin
            r_pend1 <= w_start1 ? 1'b0 : (r_pend1 | (ped_req1 & ~r_walk1));
            r_pend2 <= w_start2 ? 1'b0 : (r_pend2 | (ped_req2 & ~r_walk2));
            if (w_start1 || w_start2) begin
                r_walk1 <= w_start1;
                r_walk2 <= w_start2;
                r_wcnt  <= '0;
            end else if (w_em_any || r_preempt || (w_next != r_state) || (r_wcnt == L_WALK_END)) begin
                r_walk1 <= 1'b0;
                r_walk2 <= 1'b0;
                r_wcnt  <= '0;
            end else if (r_walk1 || r_walk2) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
        end
    end

    always_comb begin
        red1    = 1'b1;
        yellow1 = 1'b0;
        green1  = 1'b0;
        red2    = 1'b1;
        yellow2 = 1'b0;
        green2  = 1'b0;
        case (r_state)
            S_G1: begin red1 = 1'b0; green1  = 1'b1; end
            S_Y1: begin red1 = 1'b0; yellow1 = 1'b1; end
            S_G2: begin red2 = 1'b0; green2  = 1'b1; end
            S_Y2: begin red2 = 1'b0; yellow2 = 1'b1; end
            default: ;
        endcase
    end

    assign walk1          = r_walk1 & ~r_preempt & ~w_em_any;
    assign walk2          = r_walk2 & ~r_preempt & ~w_em_any;
    assign preempt_active = r_preempt;
    assign phase          = r_state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb/tb_intersection_phase_scheduler.sv - directed self-checking bench for intersection_phase_scheduler
module tb_intersection_phase_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       car1, car2, ped_req1, ped_req2;
    logic [1:0] emerg_req;
    logic       red1, yellow1, green1, red2, yellow2, green2;
    logic       walk1, walk2, preempt_active;
    logic [2:0] phase;

    int n_tests = 0;
    int n_fail  = 0;
    int n;
    int m;

    intersection_phase_scheduler dut (
        .clk(clk), .reset(reset),
        .car1(car1), .car2(car2), .ped_req1(ped_req1), .ped_req2(ped_req2),
        .emerg_req(emerg_req),
        .red1(red1), .yellow1(yellow1), .green1(green1),
        .red2(red2), .yellow2(yellow2), .green2(green2),
        .walk1(walk1), .walk2(walk2), .preempt_active(preempt_active),
        .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_for(input logic [2:0] ph, input string tag);
        int k = 0;
        while (phase !== ph && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {29'd0, phase}, {29'd0, ph});
    endtask

    task automatic measure(input logic [2:0] ph, input int lim, output int cnt);
        cnt = 0;
        while (phase === ph && cnt < lim) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic chk_reset_lamps(input string tag);
        chk({tag, "_lamps"}, {26'd0, red1, yellow1, green1, red2, yellow2, green2}, 32'b100100);
        chk({tag, "_phase"}, {29'd0, phase}, 32'd0);
        chk({tag, "_misc"}, {29'd0, walk1, walk2, preempt_active}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; car1 = 0; car2 = 0; ped_req1 = 0; ped_req2 = 0; emerg_req = 2'b00;
        repeat (2) @(negedge clk);
        chk_reset_lamps("reset");

        // Idle start-up: two all-red cycles, then G1 rests with no demand.
        reset = 1'b0;
        @(negedge clk);
        chk("init_ar0", {29'd0, phase}, 32'd0);
        @(negedge clk);
        chk("init_g1", {29'd0, phase}, 32'd1);
        chk("init_g1_lamps", {26'd0, red1, yellow1, green1, red2, yellow2, green2}, 32'b001100);
        measure(3'd1, 100, n);
        chk("g1_rest", n, 100);

        // Minimum green with road-2 demand and no own demand.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_for(3'd1, "s2_g1_entry");
        car2 = 1'b1;
        measure(3'd1, 50, n);
        chk("s2_g1_len", n, 8);
        measure(3'd2, 50, n);
        chk("s2_y1_len", n, 3);
        measure(3'd3, 50, n);
        chk("s2_ar1_len", n, 2);
        chk("s2_g2_lamps", {26'd0, red1, yellow1, green1, red2, yellow2, green2}, 32'b100001);

        // Both roads busy: each green runs to its maximum.
        car1 = 1'b1;
        wait_for(3'd5, "s3_y2");
        wait_for(3'd1, "s3_g1_entry");
        measure(3'd1, 50, n);
        chk("s3_g1_max", n, 20);
        measure(3'd2, 50, n);
        chk("s3_y1_len", n, 3);
        measure(3'd3, 50, n);
        chk("s3_ar1_len", n, 2);
        measure(3'd4, 50, n);
        chk("s3_g2_max", n, 20);
        car1 = 1'b0; car2 = 1'b0;

        // Pedestrian request for road 2 served on the next G2.
        wait_for(3'd1, "s4_g1_entry");
        chk("s4_no_walk1", {31'd0, walk1}, 32'd0);
        ped_req2 = 1'b1;
        @(negedge clk);
        ped_req2 = 1'b0;
        measure(3'd1, 50, m);
        chk("s4_g1_len", m + 1, 8);
        measure(3'd2, 50, n);
        measure(3'd3, 50, n);
        chk("s4_g2_entry", {29'd0, phase}, 32'd4);
        chk("s4_walk2_on", {31'd0, walk2}, 32'd1);
        ped_req2 = 1'b1;
        @(negedge clk);
        ped_req2 = 1'b0;
        n = 1;
        while (walk2 === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("s4_walk2_len", n, 5);
        car1 = 1'b1;
        wait_for(3'd1, "s4_g1_again");
        car1 = 1'b0; car2 = 1'b1;
        wait_for(3'd4, "s4_g2_again");
        chk("s4_absorbed", {31'd0, walk2}, 32'd0);

        // Emergency for road 2 arrives early in G1.
        car1 = 1'b1;
        wait_for(3'd1, "s5_g1_entry");
        car1 = 1'b0; car2 = 1'b0;
        ped_req2 = 1'b1;
        @(negedge clk);
        ped_req2 = 1'b0;
        @(negedge clk);
        chk("s5_g1_cnt2", {29'd0, phase}, 32'd1);
        emerg_req = 2'b10;
        @(negedge clk);
        chk("s5_y1_next", {29'd0, phase}, 32'd2);
        measure(3'd2, 50, n);
        chk("s5_y1_len", n, 3);
        measure(3'd3, 50, n);
        chk("s5_ar1_len", n, 2);
        chk("s5_g2_held", {29'd0, phase}, 32'd4);
        chk("s5_preempt_on", {31'd0, preempt_active}, 32'd1);
        chk("s5_no_walk2", {31'd0, walk2}, 32'd0);
        car1 = 1'b1;
        repeat (20) @(negedge clk);
        chk("s5_still_held", {29'd0, phase, preempt_active, walk2}, {29'd0, 3'd4, 1'b1, 1'b0});
        repeat (4) @(negedge clk);
        emerg_req = 2'b00;
        @(negedge clk);
        chk("s5_release_exit", {29'd0, phase}, 32'd5);
        chk("s5_preempt_off", {31'd0, preempt_active}, 32'd0);

        // Both emergency bits: road 1 takes the green and holds it against road-2 demand.
        emerg_req = 2'b11;
        wait_for(3'd1, "s5_g1_emerg");
        chk("s5_g1_preempt", {29'd0, preempt_active, walk1, walk2}, 32'b100);
        car1 = 1'b0; car2 = 1'b1;
        repeat (25) @(negedge clk);
        chk("s5_g1_held", {29'd0, phase, preempt_active}, {28'd0, 3'd1, 1'b1});
        emerg_req = 2'b00;
        @(negedge clk);
        chk("s5_g1_release", {29'd0, phase, preempt_active}, {28'd0, 3'd2, 1'b0});

        // Asynchronous reset in the middle of Y1.
        @(posedge clk);
        #1;
        chk("s6_in_y1", {31'd0, yellow1}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk_reset_lamps("s6_async");
        car1 = 0; car2 = 0; ped_req1 = 0; ped_req2 = 0; emerg_req = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("s6_ar0", {29'd0, phase}, 32'd0);
        @(negedge clk);
        chk("s6_g1", {29'd0, phase}, 32'd1);
        measure(3'd1, 40, n);
        chk("s6_g1_rest", n, 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
